// File: rtl/spi_shift_unit.sv
// spi_shift_unit: frame-aware SPI shift engine (LSB/MSB first, bit counter, busy, done pulse).
// Optional build macro SPI_SHIFT_UNIT_SPLIT_EDGE_EN: receive bit captured on sampleEdge, shifted on peripheralClkEdge.
module spi_shift_unit #(
    parameter int width      = 8,
    parameter int countWidth = $clog2(width) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  peripheralClkEdge,
    input  logic                  sampleEdge,
    input  logic                  parallelLoad,
    input  logic                  lsbFirst,
    input  logic [width-1:0]      parallelDataIn,
    input  logic                  serialDataIn,
    output logic [width-1:0]      parallelDataOut,
    output logic                  serialDataOut,
    output logic                  busy,
    output logic                  done,
    output logic [countWidth-1:0] bitCount
);
    // Strobe semantics: peripheralClkEdge/sampleEdge/parallelLoad are level-sampled every cycle with
    // no back-pressure; a strobe high for k cycles acts k times, and parallelLoad outranks any strobe.
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} stateT;

    stateT                 state, stateNext;
    logic [width-1:0]      mem, memNext;
    logic                  dirReg, dirNext;
    logic [countWidth-1:0] count, countNext, countInc;
    logic                  doneNext;
    logic                  shiftBit;

`ifdef SPI_SHIFT_UNIT_SPLIT_EDGE_EN
    logic sampleBit, sampleNext;

    // The shift always consumes the previously captured bit, even if a new sample lands this cycle.
    assign shiftBit = sampleBit;

    always_comb begin
        sampleNext = sampleBit;
        if (parallelLoad) begin
            sampleNext = 1'b0;
        end else if (state == SHIFT && sampleEdge) begin
            sampleNext = serialDataIn;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sampleBit <= 1'b0;
        end else begin
            sampleBit <= sampleNext;
        end
    end
`else
    logic unusedSampleEdge;

    assign unusedSampleEdge = sampleEdge;
    assign shiftBit         = serialDataIn;
`endif

    assign countInc = count + countWidth'(1);

    always_comb begin
        stateNext = state;
        memNext   = mem;
        dirNext   = dirReg;
        countNext = count;
        doneNext  = 1'b0;
        if (parallelLoad) begin
            // Load starts a frame from IDLE and restarts one from SHIFT; an aborted frame gets no done.
            memNext   = parallelDataIn;
            dirNext   = lsbFirst;
            countNext = '0;
            stateNext = SHIFT;
        end else if (state == SHIFT && peripheralClkEdge) begin
            if (dirReg) begin
                memNext = {shiftBit, mem[width-1:1]};
            end else begin
                memNext = {mem[width-2:0], shiftBit};
            end
            countNext = countInc;
            if (countInc == countWidth'(width)) begin
                doneNext  = 1'b1;
                stateNext = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mem    <= '0;
            dirReg <= 1'b1;
            count  <= '0;
            done   <= 1'b0;
        end else begin
            state  <= stateNext;
            mem    <= memNext;
            dirReg <= dirNext;
            count  <= countNext;
            done   <= doneNext;
        end
    end

    assign parallelDataOut = mem;
    assign serialDataOut   = dirReg ? mem[0] : mem[width-1];
    assign busy            = (state == SHIFT);
    assign bitCount        = count;
endmodule

// File: tb/tb_spi_shift_unit.sv
// Bench for spi_shift_unit: vector table, hand-written corner sequences, and randomized model check.
module tb_spi_shift_unit;
    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          reset, peripheralClkEdge, sampleEdge, parallelLoad, lsbFirst, serialDataIn;
    logic [W-1:0]  parallelDataIn, parallelDataOut;
    logic          serialDataOut, busy, done;
    logic [CW-1:0] bitCount;

    int nVec = 0;
    int nErr = 0;

    spi_shift_unit #(.width(W), .countWidth(CW)) dut (
        .clk(clk), .reset(reset), .peripheralClkEdge(peripheralClkEdge), .sampleEdge(sampleEdge),
        .parallelLoad(parallelLoad), .lsbFirst(lsbFirst), .parallelDataIn(parallelDataIn),
        .serialDataIn(serialDataIn), .parallelDataOut(parallelDataOut), .serialDataOut(serialDataOut),
        .busy(busy), .done(done), .bitCount(bitCount)
    );

    always #5 clk = ~clk;

    // ---------------- driver and checker ----------------
    task automatic cycle(input logic r, ld, lsb, stb, smp, input logic [W-1:0] din, input logic sin);
        reset = r; parallelLoad = ld; lsbFirst = lsb; peripheralClkEdge = stb;
        sampleEdge = smp; parallelDataIn = din; serialDataIn = sin;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chkAll(input string tag, input logic [W-1:0] ePout, input logic eSout, eBusy, eDone,
                          input logic [CW-1:0] eCnt);
        chk({tag, ".pout"}, 32'(parallelDataOut), 32'(ePout));
        chk({tag, ".sout"}, 32'(serialDataOut), 32'(eSout));
        chk({tag, ".busy"}, 32'(busy), 32'(eBusy));
        chk({tag, ".done"}, 32'(done), 32'(eDone));
        chk({tag, ".cnt"}, 32'(bitCount), 32'(eCnt));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          rst, ld, lsb, stb, smp;
        logic [W-1:0]  din;
        logic          sin;
        logic [W-1:0]  ePout;
        logic          eSout, eBusy, eDone;
        logic [CW-1:0] eCnt;
    } vecT;

    vecT vecs[$];
    vecT lastVec;

    function automatic void addVec(logic rst, ld, lsb, stb, smp, logic [W-1:0] din, logic sin,
                                   logic [W-1:0] ePout, logic eSout, eBusy, eDone, logic [CW-1:0] eCnt);
        vecT v;
        v.rst = rst; v.ld = ld; v.lsb = lsb; v.stb = stb; v.smp = smp; v.din = din; v.sin = sin;
        v.ePout = ePout; v.eSout = eSout; v.eBusy = eBusy; v.eDone = eDone; v.eCnt = eCnt;
        vecs.push_back(v);
        lastVec = v;
    endfunction

    // One shift with receive bit sin; in split-edge builds the bit is first captured by a sample cycle.
    function automatic void addShift(logic sin, logic [W-1:0] ePout, logic eSout, eBusy, eDone,
                                     logic [CW-1:0] eCnt);
`ifdef SPI_SHIFT_UNIT_SPLIT_EDGE_EN
        addVec(0, 0, 0, 0, 1, '0, sin, lastVec.ePout, lastVec.eSout, lastVec.eBusy, 1'b0, lastVec.eCnt);
        addVec(0, 0, 0, 1, 0, '0, ~sin, ePout, eSout, eBusy, eDone, eCnt);
`else
        addVec(0, 0, 0, 1, 0, '0, sin, ePout, eSout, eBusy, eDone, eCnt);
`endif
    endfunction

    // ---------------- reference model ----------------
    int   mL;
    logic mDir, mActive, mDone, mSample;
    int   rxq[$];

    function automatic int mdlMem();
        int k = rxq.size();
        int r = 0;
        int v;
        if (mDir) begin
            for (int i = 0; i < k; i++) r |= rxq[i] << i;
            v = (mL >> k) | (r << (W - k));
        end else begin
            for (int i = 0; i < k; i++) r |= rxq[i] << (k - 1 - i);
            v = (mL << k) | r;
        end
        return v & ((1 << W) - 1);
    endfunction

    function automatic void mdlStep(logic r, ld, lsb, stb, smp, logic [W-1:0] din, logic sin);
        int b;
        mDone = 1'b0;
        if (r) begin
            mL = 0; mDir = 1'b1; mActive = 1'b0; mSample = 1'b0; rxq.delete();
        end else if (ld) begin
            mL = int'(din); mDir = lsb; mActive = 1'b1; mSample = 1'b0; rxq.delete();
        end else if (mActive) begin
`ifdef SPI_SHIFT_UNIT_SPLIT_EDGE_EN
            b = int'(mSample);
            if (smp) mSample = sin;
`else
            b = int'(sin);
`endif
            if (stb) begin
                rxq.push_back(b);
                if (rxq.size() == W) begin
                    mActive = 1'b0;
                    mDone = 1'b1;
                end
            end
        end
    endfunction

    // ---------------- test sequence ----------------
    logic splitOn;

    initial begin
`ifdef SPI_SHIFT_UNIT_SPLIT_EDGE_EN
        splitOn = 1'b1;
`else
        splitOn = 1'b0;
`endif
        // Reset under garbage inputs, ignored idle strobe, then LSB-first 0xA5 frame.
        addVec(1, 1, 0, 1, 1, 8'hFF, 1, 8'h00, 0, 0, 0, 0);
        addVec(0, 0, 1, 1, 0, 8'hFF, 1, 8'h00, 0, 0, 0, 0);
        addVec(0, 1, 1, 0, 0, 8'hA5, 0, 8'hA5, 1, 1, 0, 0);
        addShift(1, 8'hD2, 0, 1, 0, 1);
        addShift(0, 8'h69, 1, 1, 0, 2);
        addShift(1, 8'hB4, 0, 1, 0, 3);
        addShift(0, 8'h5A, 0, 1, 0, 4);
        addShift(1, 8'hAD, 1, 1, 0, 5);
        addShift(0, 8'h56, 0, 1, 0, 6);
        addShift(1, 8'hAB, 1, 1, 0, 7);
        addShift(0, 8'h55, 1, 0, 1, 8);
        addVec(0, 0, 0, 1, 0, 8'h00, 1, 8'h55, 1, 0, 0, 8);
        // MSB-first 0xC4 with all-ones receive, then a load in the done cycle.
        addVec(0, 1, 0, 0, 0, 8'hC4, 1, 8'hC4, 1, 1, 0, 0);
        addShift(1, 8'h89, 1, 1, 0, 1);
        addShift(1, 8'h13, 0, 1, 0, 2);
        addShift(1, 8'h27, 0, 1, 0, 3);
        addShift(1, 8'h4F, 0, 1, 0, 4);
        addShift(1, 8'h9F, 1, 1, 0, 5);
        addShift(1, 8'h3F, 0, 1, 0, 6);
        addShift(1, 8'h7F, 0, 1, 0, 7);
        addShift(1, 8'hFF, 1, 0, 1, 8);
        addVec(0, 1, 1, 1, 0, 8'h0F, 0, 8'h0F, 1, 1, 0, 0);

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].ld, vecs[i].lsb, vecs[i].stb, vecs[i].smp, vecs[i].din, vecs[i].sin);
            chkAll($sformatf("vec%0d", i), vecs[i].ePout, vecs[i].eSout, vecs[i].eBusy, vecs[i].eDone,
                   vecs[i].eCnt);
        end

        // Restart: three strobes, then reload with a simultaneous strobe; done only after 8 more.
        cycle(1, 0, 0, 0, 0, '0, 0);
        cycle(0, 1, 1, 0, 0, 8'h33, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, '0, 1);
        chk("restart.cnt3", 32'(bitCount), 3);
        cycle(0, 1, 1, 1, 1, 8'h0F, 1);
        chkAll("restart.load", 8'h0F, 1, 1, 0, 0);
        for (int i = 1; i <= W; i++) begin
            cycle(0, 0, 0, 1, 0, '0, 0);
            chk($sformatf("restart.done%0d", i), 32'(done), (i == W) ? 1 : 0);
            chk($sformatf("restart.cnt%0d", i), 32'(bitCount), 32'(i));
        end
        cycle(0, 0, 0, 0, 0, '0, 0);
        chk("restart.doneFall", 32'(done), 0);

        // Reset mid-frame after five strobes.
        cycle(0, 1, 0, 0, 0, 8'h5A, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 1, 1, '0, 1);
            chk("midReset.noDone", 32'(done), 0);
        end
        cycle(1, 0, 0, 1, 0, '0, 1);
        chkAll("midReset", 8'h00, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, '0, 1);
        chkAll("midReset.after", 8'h00, 0, 0, 0, 0);

        // Split-edge sample behaviour versus direct sampling.
        cycle(0, 1, 1, 0, 0, 8'h00, 0);
        cycle(0, 0, 0, 0, 1, '0, 1);
        cycle(0, 0, 0, 0, 0, '0, 0);
        cycle(0, 0, 0, 1, 0, '0, 0);
        chk("split.first", 32'(parallelDataOut[W-1]), splitOn ? 1 : 0);
        cycle(0, 0, 0, 1, 1, '0, 0);
        chk("split.sameCycle", 32'(parallelDataOut[W-1]), splitOn ? 1 : 0);
        cycle(0, 0, 0, 1, 0, '0, 1);
        chk("split.newSample", 32'(parallelDataOut[W-1]), splitOn ? 0 : 1);

        // Randomized run against the reference model.
        cycle(1, 0, 0, 0, 0, '0, 0);
        mdlStep(1, 0, 0, 0, 0, '0, 0);
        for (int n = 0; n < 1500; n++) begin
            logic r, ld, lsb, stb, smp, sin;
            logic [W-1:0] din;
            logic [W-1:0] em;
            r   = ($urandom_range(0, 79) == 0);
            ld  = ($urandom_range(0, 13) == 0);
            lsb = 1'($urandom_range(0, 1));
            stb = 1'($urandom_range(0, 1));
            smp = 1'($urandom_range(0, 1));
            sin = 1'($urandom_range(0, 1));
            din = W'($urandom);
            cycle(r, ld, lsb, stb, smp, din, sin);
            mdlStep(r, ld, lsb, stb, smp, din, sin);
            em = W'(mdlMem());
            chkAll("rand", em, mDir ? em[0] : em[W-1], mActive, mDone, CW'(rxq.size()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule

// File: doc/spi_shift_unit.md
# spi_shift_unit

Parametrised, frame-aware shift engine for the SPI peripheral datapath. It loads a `width`-bit word, shifts it out LSB-first or MSB-first on single-cycle strobes from the serial-clock edge detector, and shifts received bits in. It counts bits, reports `busy`, and pulses `done` when a full frame has been exchanged. It replaces the free-running, LSB-only, fixed-frame shift register in the peripheral datapath.

## Interface
- `width`, 8, frame length in bits (≥2)
- `countWidth`, `$clog2(width)+1`, width of `bitCount` (must hold value `width`)

- `clk`  in  1  system clock, all logic on posedge
- `reset`  in  1  synchronous, active-high reset
- `peripheralClkEdge`  in  1  one-cycle shift strobe (serial-clock shift edge)
- `sampleEdge`  in  1  one-cycle sample strobe; used only with `SPI_SHIFT_UNIT_SPLIT_EDGE_EN`
- `parallelLoad`  in  1  load `parallelDataIn` and start a frame
- `lsbFirst`  in  1  frame bit order, latched on load (1 = LSB first)
- `parallelDataIn`  in  `width`  word to transmit
- `serialDataIn`  in  1  received serial bit
- `parallelDataOut`  out  `width`  shift register contents
- `serialDataOut`  out  1  current transmit bit
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse at frame completion
- `bitCount`  out  `countWidth`  bits shifted in the current frame

## Operation
- Registers: `mem[width-1:0]`, `dirReg`, `count`, `state` (IDLE/SHIFT), `done`.
- `serialDataOut = dirReg ? mem[0] : mem[width-1]` (combinational from registers). `parallelDataOut = mem`. `busy = (state==SHIFT)`.
- Reset values: `mem=0`, `dirReg=1`, `count=0`, `state=IDLE`, `done=0`, sample bit 0. Therefore `serialDataOut=0`, `parallelDataOut=0`, `busy=0`, `bitCount=0`.
- IDLE:
  - `parallelLoad=1`: `mem<=parallelDataIn`, `dirReg<=lsbFirst`, `count<=0`, go to SHIFT.
  - `peripheralClkEdge` is ignored; `mem` holds.
- SHIFT, in priority order:
  - `parallelLoad=1`: reload exactly as in IDLE (restart). The aborted frame produces no `done`. Any simultaneous strobe is ignored.
  - Else on `peripheralClkEdge=1`, with input bit b:
    - `dirReg=1`: `mem<={b, mem[width-1:1]}`.
    - `dirReg=0`: `mem<={mem[width-2:0], b}`.
    - `count<=count+1`.
  - If that strobe makes `count==width`: `done<=1` for one cycle and go to IDLE.
- `count` stays at `width` in IDLE until the next load. It never wraps.
- `done` is 0 in every cycle other than the one after the final shift.
- Reset asserted mid-frame overrides everything. All state returns to reset values on that edge, with no `done`.

## Timing
- Load at edge N: `parallelDataOut`, `serialDataOut`, and `busy=1` are valid after N.
- Each shift takes effect at the edge that samples the strobe. The next transmit bit appears after that edge.
- Final (`width`-th) strobe sampled at edge M: after M, `busy=0`, `done=1`, `bitCount=width`, and `parallelDataOut` is the received word. After M+1, `done=0`.
- Load in the same cycle as `done` is high: accepted, and a new frame starts.
- Strobes are level-sampled per cycle. A strobe held high for k cycles shifts k times.

## Configuration
- `SPI_SHIFT_UNIT_SPLIT_EDGE_EN` defined:
  - In SHIFT, `sampleEdge=1` captures `serialDataIn` into a sample register.
  - `peripheralClkEdge` shifts in the sample register, so b = sample bit.
  - `sampleEdge` and `peripheralClkEdge` in the same cycle: the shift uses the old sample bit, and the sample register takes the new value.
  - The sample register is cleared on reset and on load.
- Not defined: b = `serialDataIn` at the shift edge, and `sampleEdge` is ignored (no sample register).

## Test plan
- Reset: drive garbage, assert `reset` one cycle -> `parallelDataOut=0x00`, `serialDataOut=0`, `busy=0`, `done=0`, `bitCount=0`. Strobes while IDLE leave `mem=0x00`.
- LSB first: load `0xA5` with `lsbFirst=1`, then 8 strobes with `serialDataIn` = 1,0,1,0,1,0,1,0 -> `serialDataOut` before each strobe is 1,0,1,0,0,1,0,1. Final `parallelDataOut=0x55`, exactly one `done` pulse, `busy` falls with it, `bitCount=8`.
- MSB first: load `0xC4` with `lsbFirst=0`, `serialDataIn=1`, 8 strobes -> `serialDataOut` is 1,1,0,0,0,1,0,0. Final `0xFF`, one `done`.
- Restart: 3 strobes into a frame, load `0x0F` -> `bitCount=0`, no `done`. `done` arrives only after 8 further strobes.
- Reset mid-frame: after 5 strobes assert `reset` -> next cycle `busy=0`, `bitCount=0`, `mem=0`. No `done` at any point.
- Split edge (macro on): `sampleEdge` with `serialDataIn=1`, then `serialDataIn=0`, then strobe (LSB first) -> `mem[width-1]=1`. Macro off, same stimulus -> `mem[width-1]=0`.
